// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared encodings and constants for the iterative multiply/divide unit
package mdu_pkg;

    localparam int          ITER    = 32;
    localparam logic [31:0] DIV0_LO = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIN  = 2'b10
    } state_e;

endpackage

// File: rtl/mdu_abs32.sv
// rtl/mdu_abs32.sv - conditional two's-complement negate; i_cin=1 gives magnitude/negate,
// i_cin=borrow-from-low-word lets two instances negate a 64-bit value
module mdu_abs32 (
    input  logic [31:0] i_val,
    input  logic        i_neg,
    input  logic        i_cin,
    output logic [31:0] o_val
);

    assign o_val = i_neg ? (~i_val + {31'd0, i_cin}) : i_val;

endmodule

// File: rtl/mdu_iter32.sv
// rtl/mdu_iter32.sv - radix-2 iterative MULT/MULTU/DIV/DIVU with HI/LO pair
// Optional: MDU_EARLY_TERM_EN lets multiplies leave RUN once the remaining multiplier is zero.
module mdu_iter32
    import mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            clrn,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            wr_hi,
    input  logic            wr_lo,
    input  logic [XLEN-1:0] wdata,
    output logic            busy,
    output logic            pc_en,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    state_e      r_state, w_state_nxt;
    logic [4:0]  r_cnt;
    logic [31:0] r_opd, r_acc, r_mq, r_hi, r_lo;
    logic        r_is_div, r_neg_q, r_neg_r, r_div0, r_done;

    logic        w_is_div, w_sgn;
    logic [31:0] w_abs_a, w_abs_b;
    logic [32:0] w_add, w_shl, w_diff;
    logic        w_qbit;
    logic [31:0] w_acc_nxt, w_mq_nxt;
    logic        w_early;
    logic [63:0] w_prod;
    logic [31:0] w_fin_hi, w_fin_lo, w_res_hi, w_res_lo;

    assign w_is_div = (op == OP_DIV) || (op == OP_DIVU);
    assign w_sgn    = (op == OP_MULT) || (op == OP_DIV);

    mdu_abs32 u_abs_a (.i_val(a), .i_neg(w_sgn & a[31]), .i_cin(1'b1), .o_val(w_abs_a));
    mdu_abs32 u_abs_b (.i_val(b), .i_neg(w_sgn & b[31]), .i_cin(1'b1), .o_val(w_abs_b));

    // r_acc is product-high / partial remainder; r_mq is multiplier->product-low / dividend->quotient
    always_comb begin
        w_add  = {1'b0, r_acc} + (r_mq[0] ? {1'b0, r_opd} : 33'd0);
        w_shl  = {r_acc, r_mq[31]};
        w_diff = w_shl - {1'b0, r_opd};
        w_qbit = ~w_diff[32];
        if (r_is_div) begin
            w_acc_nxt = w_qbit ? w_diff[31:0] : w_shl[31:0];
            w_mq_nxt  = {r_mq[30:0], w_qbit};
        end else begin
            w_acc_nxt = w_add[32:1];
            w_mq_nxt  = {w_add[0], r_mq[31:1]};
        end
    end

`ifdef MDU_EARLY_TERM_EN
    // The low r_cnt bits of the shifted register are the multiplier bits still to consume;
    // on early exit r_cnt is kept and the pending right shifts are applied in FIN.
    assign w_early = ~r_is_div && ((w_mq_nxt & ((32'd1 << r_cnt) - 32'd1)) == 32'd0);
    assign w_prod  = {r_acc, r_mq} >> r_cnt;
`else
    assign w_early = 1'b0;
    assign w_prod  = {r_acc, r_mq};
`endif

    assign w_fin_hi = r_is_div ? r_acc : w_prod[63:32];
    assign w_fin_lo = r_is_div ? r_mq  : w_prod[31:0];

    mdu_abs32 u_fix_lo (
        .i_val (w_fin_lo),
        .i_neg (r_neg_q),
        .i_cin (1'b1),
        .o_val (w_res_lo)
    );
    mdu_abs32 u_fix_hi (
        .i_val (w_fin_hi),
        .i_neg (r_is_div ? r_neg_r : r_neg_q),
        .i_cin (r_is_div ? 1'b1 : (w_fin_lo == 32'd0)),
        .o_val (w_res_hi)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if ((r_cnt == 5'd0) || w_early) w_state_nxt = S_FIN;
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_cnt    <= 5'd0;
            r_opd    <= 32'd0;
            r_acc    <= 32'd0;
            r_mq     <= 32'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == S_FIN);
            case (r_state)
                S_IDLE: begin
                    if (wr_hi) r_hi <= wdata;
                    if (wr_lo) r_lo <= wdata;
                    if (start) begin
                        r_is_div <= w_is_div;
                        r_opd    <= w_is_div ? w_abs_b : w_abs_a;
                        r_mq     <= w_is_div ? w_abs_a : w_abs_b;
                        r_acc    <= 32'd0;
                        r_neg_q  <= w_sgn & (a[31] ^ b[31]);
                        r_neg_r  <= w_sgn & a[31];
                        r_div0   <= w_is_div && (b == 32'd0);
                        r_cnt    <= 5'(ITER - 1);
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_nxt;
                    r_mq  <= w_mq_nxt;
                    if ((r_cnt != 5'd0) && !w_early) r_cnt <= r_cnt - 5'd1;
                end
                S_FIN: begin
                    r_hi <= w_res_hi;
                    r_lo <= r_div0 ? DIV0_LO : w_res_lo;
                end
                default: ;
            endcase
        end
    end

    assign busy  = (r_state != S_IDLE);
    assign pc_en = ~busy;
    assign done  = r_done;
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule

// File: tb/tb_mdu_iter32.sv
// tb/tb_mdu_iter32.sv - directed bench with cycle-level behavioural model of mdu_iter32
module tb_mdu_iter32;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        wr_hi = 1'b0;
    logic        wr_lo = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic        busy, pc_en, done;
    logic [31:0] hi, lo;

    always #5 clk = ~clk;

    mdu_iter32 dut (
        .clk   (clk),
        .clrn  (clrn),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .wr_hi (wr_hi),
        .wr_lo (wr_lo),
        .wdata (wdata),
        .busy  (busy),
        .pc_en (pc_en),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Architectural result {hi,lo} for one operation, straight from MIPS semantics
    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x,
                                               input logic [31:0] y);
        longint sx, sy;
        int     qi, ri;
        logic [63:0] r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'b00: r = 64'(sx * sy);
            2'b01: r = {32'd0, x} * {32'd0, y};
            2'b10: begin
                if (y == 32'd0) r = {x, 32'hFFFFFFFF};
                else if (x == 32'h80000000 && y == 32'hFFFFFFFF) r = {32'd0, 32'h80000000};
                else begin
                    qi = $signed(x) / $signed(y);
                    ri = $signed(x) % $signed(y);
                    r  = {32'(ri), 32'(qi)};
                end
            end
            default: begin
                if (y == 32'd0) r = {x, 32'hFFFFFFFF};
                else r = {x % y, x / y};
            end
        endcase
        return r;
    endfunction

    int          m_cnt  = 0;
    logic        m_done = 1'b0;
    logic [31:0] m_hi   = 32'd0;
    logic [31:0] m_lo   = 32'd0;
    logic [63:0] m_pend = 64'd0;

    always @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            m_cnt  = 0;
            m_done = 1'b0;
            m_hi   = 32'd0;
            m_lo   = 32'd0;
        end else begin
            m_done = 1'b0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    {m_hi, m_lo} = m_pend;
                    m_done = 1'b1;
                end
            end else begin
                if (wr_hi) m_hi = wdata;
                if (wr_lo) m_lo = wdata;
                if (start) begin
                    m_pend = ref_result(op, a, b);
                    m_cnt  = 33;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_busy",  64'(busy),  64'(m_cnt > 0));
            chk("cyc_pc_en", 64'(pc_en), 64'(m_cnt == 0));
            chk("cyc_done",  64'(done),  64'(m_done));
            chk("cyc_hi",    64'(hi),    64'(m_hi));
            chk("cyc_lo",    64'(lo),    64'(m_lo));
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        op    = ~o;
        a     = ~x;
        b     = y ^ 32'h5A5A5A5A;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo);
        int lat;
        issue(o, x, y);
        wait_done(lat);
        chk({nm, "_lat"}, 64'(lat), 64'd33);
        chk({nm, "_hi"},  64'(hi),  64'(ehi));
        chk({nm, "_lo"},  64'(lo),  64'(elo));
    endtask

    initial begin
        int lat;
        int seen;
        repeat (3) @(negedge clk);
        chk("rst_busy",  64'(busy),  64'd0);
        chk("rst_pc_en", 64'(pc_en), 64'd1);
        chk("rst_done",  64'(done),  64'd0);
        chk("rst_hi",    64'(hi),    64'd0);
        chk("rst_lo",    64'(lo),    64'd0);

        chk("ref_multu", ref_result(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF), 64'hFFFFFFFE_00000001);
        chk("ref_mult",  ref_result(2'b00, 32'hFFFFFFF9, 32'd6),        64'hFFFFFFFF_FFFFFFD6);
        chk("ref_div",   ref_result(2'b10, 32'hFFFFFFEF, 32'd5),        64'hFFFFFFFE_FFFFFFFD);
        chk("ref_divu",  ref_result(2'b11, 32'd100, 32'd7),             64'h00000002_0000000E);
        chk("ref_div0",  ref_result(2'b10, 32'hFFFFFB2E, 32'd0),        64'hFFFFFB2E_FFFFFFFF);
        chk("ref_ovf",   ref_result(2'b10, 32'h80000000, 32'hFFFFFFFF), 64'h00000000_80000000);

        clrn   = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_op("mult_neg",  2'b00, 32'hFFFFFFF9, 32'd6,        32'hFFFFFFFF, 32'hFFFFFFD6);
        run_op("mult_minn", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
        run_op("div_neg",   2'b10, 32'hFFFFFFEF, 32'd5,        32'hFFFFFFFE, 32'hFFFFFFFD);
        run_op("div_negb",  2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
        run_op("divu",      2'b11, 32'd100,      32'd7,        32'd2,        32'd14);
        run_op("divu_z",    2'b11, 32'd1234,     32'd0,        32'd1234,     32'hFFFFFFFF);
        run_op("div_z_neg", 2'b10, 32'hFFFFFB2E, 32'd0,        32'hFFFFFB2E, 32'hFFFFFFFF);
        run_op("div_ovf",   2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000);

        issue(2'b01, 32'h12345678, 32'h10);
        for (int i = 0; i < 20; i++) begin
            start = 1'b1;
            op    = 2'b10;
            a     = 32'd1;
            b     = 32'd1;
            wr_hi = i[0];
            wr_lo = ~i[0];
            wdata = 32'(i) + 32'h100;
            @(negedge clk);
        end
        start = 1'b0;
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        wait_done(lat);
        chk("ign_lat", 64'(lat), 64'd13);
        chk("ign_hi",  64'(hi),  64'h1);
        chk("ign_lo",  64'(lo),  64'h23456780);
        wr_hi = 1'b1;
        wdata = 32'hA5A5A5A5;
        @(negedge clk);
        wr_hi = 1'b0;
        chk("mthi_hi", 64'(hi), 64'hA5A5A5A5);
        chk("mthi_lo", 64'(lo), 64'h23456780);

        start = 1'b1;
        op    = 2'b11;
        a     = 32'd100;
        b     = 32'd7;
        wr_lo = 1'b1;
        wdata = 32'hDEADBEEF;
        @(negedge clk);
        start = 1'b0;
        wr_lo = 1'b0;
        chk("same_lo_now", 64'(lo), 64'hDEADBEEF);
        wait_done(lat);
        chk("same_lat", 64'(lat), 64'd33);
        chk("same_hi",  64'(hi),  64'd2);
        chk("same_lo",  64'(lo),  64'd14);

        issue(2'b10, 32'hFFFFFFEF, 32'd5);
        repeat (9) @(negedge clk);
        #1 clrn = 1'b0;
        #1;
        chk("abort_busy",  64'(busy),  64'd0);
        chk("abort_pc_en", 64'(pc_en), 64'd1);
        chk("abort_done",  64'(done),  64'd0);
        chk("abort_hi",    64'(hi),    64'd0);
        chk("abort_lo",    64'(lo),    64'd0);
        @(negedge clk);
        #1 clrn = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("abort_no_done", 64'(seen), 64'd0);
        run_op("multu_small", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12);

        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
